pwm_multi_gen: RTL

Multi-channel PWM generator for the car motor-drive path. One shared period counter drives CHANNELS independent duty comparators. Each channel produces a complementary high-side/low-side pair with programmable dead time. Period, duty and dead-time settings sit in shadow registers that only update at a period boundary, so PWM waveforms never glitch when software rewrites them.

---
 rtl/pwm_multi_gen.sv | 104 ++++++++++
 1 files changed

// File: rtl/pwm_multi_gen.sv
// Multi-channel complementary PWM generator with dead-time insertion.
// Period, duty and dead-time settings are shadowed and only change at a period wrap.
module pwm_multi_gen #(
    parameter int CHANNELS = 4,
    parameter int CNT_W    = 32,
    parameter int DEAD_W   = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CNT_W-1:0]          period,
    input  logic [CHANNELS*CNT_W-1:0] duty,
    input  logic [DEAD_W-1:0]         dead,
    input  logic [CHANNELS-1:0]       ch_en,
    input  logic                      cfg_load,
    output logic [CHANNELS-1:0]       pwm_h,
    output logic [CHANNELS-1:0]       pwm_l,
    output logic                      period_end,
    output logic                      upd_ack
);

    logic [CNT_W-1:0]           cnt;
    logic [CNT_W-1:0]           period_sh;
    logic [CHANNELS*CNT_W-1:0]  duty_sh;
    logic [DEAD_W-1:0]          dead_sh;
    logic                       pending;
    logic                       wrap;
    logic                       load;
    logic [CHANNELS-1:0]        raw;
    logic [CHANNELS-1:0]        raw_q;
    logic [CHANNELS*DEAD_W-1:0] dcnt;

    // A cfg_load on the wrap cycle itself is honoured immediately.
    assign wrap = (cnt >= period_sh);
    assign load = wrap && (pending || cfg_load);

    always_comb begin
        raw = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            raw[i] = (duty_sh[i*CNT_W +: CNT_W] > cnt);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            period_sh  <= '0;
            duty_sh    <= '0;
            dead_sh    <= '0;
            pending    <= 1'b0;
            period_end <= 1'b0;
            upd_ack    <= 1'b0;
        end else begin
            cnt        <= wrap ? '0 : cnt + CNT_W'(1);
            period_end <= wrap;
            upd_ack    <= load;
            if (load) begin
                period_sh <= period;
                duty_sh   <= duty;
                dead_sh   <= dead;
                pending   <= 1'b0;
            end else if (cfg_load) begin
                pending <= 1'b1;
            end
        end
    end

    // Output stage: raw_q holds the last accepted level, dcnt the remaining dead cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            pwm_h <= '0;
            pwm_l <= '0;
            raw_q <= '0;
            dcnt  <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (!ch_en[i]) begin
                    // Inverting raw_q guarantees a dead gap on re-enable.
                    pwm_h[i]                  <= 1'b0;
                    pwm_l[i]                  <= 1'b0;
                    dcnt[i*DEAD_W +: DEAD_W]  <= '0;
                    raw_q[i]                  <= ~raw[i];
                end else if (dead_sh == '0) begin
                    pwm_h[i]                  <= raw[i];
                    pwm_l[i]                  <= ~raw[i];
                    dcnt[i*DEAD_W +: DEAD_W]  <= '0;
                    raw_q[i]                  <= raw[i];
                end else if (raw[i] != raw_q[i]) begin
                    pwm_h[i]                  <= 1'b0;
                    pwm_l[i]                  <= 1'b0;
                    dcnt[i*DEAD_W +: DEAD_W]  <= dead_sh - DEAD_W'(1);
                    raw_q[i]                  <= raw[i];
                end else if (dcnt[i*DEAD_W +: DEAD_W] != '0) begin
                    pwm_h[i]                  <= 1'b0;
                    pwm_l[i]                  <= 1'b0;
                    dcnt[i*DEAD_W +: DEAD_W]  <= dcnt[i*DEAD_W +: DEAD_W] - DEAD_W'(1);
                end else begin
                    pwm_h[i]                  <= raw_q[i];
                    pwm_l[i]                  <= ~raw_q[i];
                end
            end
        end
    end

endmodule
